// File: rtl/tile_map_renderer_if.sv
// rtl/tile_map_renderer_if.sv - scan, tile-write and render signals of the tile-map renderer
// Ports (master = VGA/game side, slave = renderer):
//   pixelX/pixelY, startOfFrame  scan position and frame pulse into the renderer
//   init_req, wr_en/col/row/type map reload and single-tile write into the renderer
//   busy, drawingRequest, RGBout, HitEdgeCode, tileType  render results out of the renderer
interface tile_map_renderer_if #(
    parameter int MAP_COLS = 10,
    parameter int MAP_ROWS = 15
);
    localparam int COL_W = $clog2(MAP_COLS);
    localparam int ROW_W = $clog2(MAP_ROWS);

    logic [10:0]      pixelX;
    logic [10:0]      pixelY;
    logic             startOfFrame;
    logic             init_req;
    logic             wr_en;
    logic [COL_W-1:0] wr_col;
    logic [ROW_W-1:0] wr_row;
    logic [1:0]       wr_type;
    logic             busy;
    logic             drawingRequest;
    logic [7:0]       RGBout;
    logic [3:0]       HitEdgeCode;
    logic [1:0]       tileType;

    modport master (
        output pixelX, pixelY, startOfFrame, init_req, wr_en, wr_col, wr_row, wr_type,
        input  busy, drawingRequest, RGBout, HitEdgeCode, tileType
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, init_req, wr_en, wr_col, wr_row, wr_type,
        output busy, drawingRequest, RGBout, HitEdgeCode, tileType
    );
endinterface

// File: rtl/tile_map_renderer.sv
// rtl/tile_map_renderer.sv - two-stage tile-map pixel renderer with run-time writable map
// Ports:
//   clk     system clock
//   resetN  synchronous active-low reset; restarts the map initialisation
//   bus     tile_map_renderer_if.slave: scan pixel in, tile writes in, colour/edge/type out
module tile_map_renderer #(
    parameter int         TILE_W_BITS          = 6,
    parameter int         TILE_H_BITS          = 5,
    parameter int         MAP_COLS             = 10,
    parameter int         MAP_ROWS             = 15,
    parameter int         FLOOR_THICK          = 4,
    parameter int         BLINK_FRAMES         = 16,
    parameter logic [7:0] FLOOR_COLOR          = 8'hA1,
    parameter logic [7:0] GIFT_COLOR           = 8'hBB,
    parameter logic [7:0] WALL_COLOR           = 8'h49,
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF
) (
    input  logic            clk,
    input  logic            resetN,
    tile_map_renderer_if.slave bus
);
    localparam int N          = MAP_COLS * MAP_ROWS;
    localparam int ADDR_W     = $clog2(N);
    localparam int TILE_W     = 1 << TILE_W_BITS;
    localparam int TILE_H     = 1 << TILE_H_BITS;
    localparam int FLOOR_BASE = (MAP_ROWS - 1) * MAP_COLS;
    localparam int PCOL_W     = 11 - TILE_W_BITS;
    localparam int PROW_W     = 11 - TILE_H_BITS;
    localparam int FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {IDLE, INIT} state_t;

    logic [1:0]        tile_map [N];
    state_t            state;
    logic [ADDR_W-1:0] init_addr;
    logic              busy_q;
    logic [FRAME_W-1:0] frame_cnt;
    logic              blink;

    // ---------------- init FSM ----------------
    // Reset parks the FSM in INIT at address 0, so the first cycle after release writes entry 0.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= INIT;
            init_addr <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.init_req) begin
                        state     <= INIT;
                        init_addr <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                INIT: begin
                    if (init_addr == ADDR_W'(N - 1)) begin
                        state     <= IDLE;
                        init_addr <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
                default: begin
                    state  <= INIT;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- map write port ----------------
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr;

    // A same-cycle init_req takes precedence, so the write is dropped.
    assign wr_ok   = bus.wr_en && (state == IDLE) && !bus.init_req
                     && (32'(bus.wr_col) < MAP_COLS) && (32'(bus.wr_row) < MAP_ROWS);
    assign wr_addr = ADDR_W'(32'(bus.wr_row) * MAP_COLS + 32'(bus.wr_col));

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            tile_map[init_addr] <= (32'(init_addr) >= FLOOR_BASE) ? 2'b01 : 2'b00;
        end else if (wr_ok) begin
            tile_map[wr_addr] <= bus.wr_type;
        end
    end

    // ---------------- blink timer ----------------
    always_ff @(posedge clk) begin
        if (!resetN) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (bus.startOfFrame) begin
            if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // ---------------- stage 1: decode and map read ----------------
    logic [PCOL_W-1:0] pix_col;
    logic [PROW_W-1:0] pix_row;
    logic              pix_in_range;
    logic [ADDR_W-1:0] pix_addr;

    assign pix_col      = bus.pixelX[10:TILE_W_BITS];
    assign pix_row      = bus.pixelY[10:TILE_H_BITS];
    assign pix_in_range = (32'(pix_col) < MAP_COLS) && (32'(pix_row) < MAP_ROWS);
    // Out-of-range pixels read entry 0; the registered range flag masks the result.
    assign pix_addr     = pix_in_range ? ADDR_W'(32'(pix_row) * MAP_COLS + 32'(pix_col)) : '0;

    logic [1:0]             s1_type;
    logic                   s1_in_range;
    logic [TILE_W_BITS-1:0] s1_offx;
    logic [TILE_H_BITS-1:0] s1_offy;

    // Registered read returns the pre-write value when a write hits the same edge.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            s1_type     <= 2'b00;
            s1_in_range <= 1'b0;
            s1_offx     <= '0;
            s1_offy     <= '0;
        end else begin
            s1_type     <= tile_map[pix_addr];
            s1_in_range <= pix_in_range;
            s1_offx     <= bus.pixelX[TILE_W_BITS-1:0];
            s1_offy     <= bus.pixelY[TILE_H_BITS-1:0];
        end
    end

    // ---------------- stage 2: colour and edge code ----------------
    logic [1:0] type_eff;
    logic [1:0] qx;
    logic [1:0] qy;
    logic       in_floor;
    logic       gift_on;
    logic [7:0] rgb_next;
    logic [3:0] hit_next;
    logic [1:0] type_next;

    assign type_eff = s1_in_range ? s1_type : 2'b00;
    assign qx       = s1_offx[TILE_W_BITS-1 -: 2];
    assign qy       = s1_offy[TILE_H_BITS-1 -: 2];
    assign in_floor = 32'(s1_offy) >= (TILE_H - FLOOR_THICK);
    assign gift_on  = (32'(s1_offx) >= TILE_W / 4) && (32'(s1_offx) < (3 * TILE_W) / 4)
                      && (32'(s1_offy) >= TILE_H / 4) && (32'(s1_offy) < (3 * TILE_H) / 4)
                      && !blink;

    always_comb begin
        rgb_next  = TRANSPARENT_ENCODING;
        hit_next  = 4'b0000;
        type_next = type_eff;
        case (type_eff)
            2'b01:   if (in_floor) rgb_next = FLOOR_COLOR;
            2'b10:   if (gift_on)  rgb_next = GIFT_COLOR;
            2'b11:   rgb_next = WALL_COLOR;
            default: rgb_next = TRANSPARENT_ENCODING;
        endcase
        if (type_eff != 2'b00) begin
            hit_next = {qx == 2'd0, qy == 2'd0, qx == 2'd3, qy == 2'd3};
        end
        // Map contents are meaningless while initialising.
        if (busy_q) begin
            rgb_next  = TRANSPARENT_ENCODING;
            hit_next  = 4'b0000;
            type_next = 2'b00;
        end
    end

    logic [7:0] rgb_q;
    logic       draw_q;
    logic [3:0] hit_q;
    logic [1:0] type_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            rgb_q  <= TRANSPARENT_ENCODING;
            draw_q <= 1'b0;
            hit_q  <= 4'b0000;
            type_q <= 2'b00;
        end else begin
            rgb_q  <= rgb_next;
            draw_q <= (rgb_next != TRANSPARENT_ENCODING);
            hit_q  <= hit_next;
            type_q <= type_next;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.RGBout         = rgb_q;
    assign bus.drawingRequest = draw_q;
    assign bus.HitEdgeCode    = hit_q;
    assign bus.tileType       = type_q;
endmodule
